// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame controller; owns edge/bit counters, checker enables and the
// per-frame data_valid / framing_err pulse.
module uart_rx_fsm #(
   parameter int WIDTH          = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic                      PAR_EN,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      strt_glitch,
   input  logic                      par_err,
   input  logic                      stp_err,
   output logic [4:0]                edge_cnt,
   output logic [3:0]                bit_cnt,
   output logic                      dat_samp_en,
   output logic                      strt_chk_en,
   output logic                      deser_en,
   output logic                      par_chk_en,
   output logic                      stp_chk_en,
   output logic                      data_valid,
   output logic                      framing_err
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
   state_t                    state_q, state_d;
   logic [4:0]                edge_q, edge_d;
   logic [3:0]                bit_q, bit_d;
   logic [PRESCALE_WIDTH-1:0] ps_q, ps_d, ps_sel;
   logic                      pen_q, pen_d, par_q, par_d, stp_q, stp_d, last;
   assign ps_sel = (prescale == PRESCALE_WIDTH'(8) || prescale == PRESCALE_WIDTH'(16) ||
                    prescale == PRESCALE_WIDTH'(32)) ? prescale : PRESCALE_WIDTH'(8);
   assign last = PRESCALE_WIDTH'(edge_q) == ps_q - PRESCALE_WIDTH'(1);
   always_comb begin
      state_d = state_q;
      edge_d  = last ? 5'd0 : edge_q + 5'd1;
      bit_d   = bit_q;
      ps_d    = ps_q;
      pen_d   = pen_q;
      par_d   = par_q;
      stp_d   = stp_q;
      case (state_q)
         IDLE, DONE: begin
            // the cycle RX_IN is first seen low is edge 0 of the start bit
            edge_d  = {4'd0, ~RX_IN};
            state_d = RX_IN ? IDLE : START;
            ps_d    = RX_IN ? ps_q : ps_sel;
            par_d   = (state_q == DONE) ? 1'b0 : par_q;
            stp_d   = (state_q == DONE) ? 1'b0 : stp_q;
         end
         START: begin
            state_d = last ? (strt_glitch ? IDLE : DATA) : START;
            bit_d   = last ? 4'd0 : bit_q;
         end
         DATA: begin
            if (last && bit_q == 4'(WIDTH - 1)) begin
               state_d = PAR_EN ? PARITY : STOP;
               pen_d   = PAR_EN;
            end else if (last) begin
               bit_d = bit_q + 4'd1;
            end
         end
         PARITY: begin
            state_d = last ? STOP : PARITY;
            par_d   = last ? par_err & pen_q : par_q;
         end
         STOP: begin
            state_d = last ? DONE : STOP;
            stp_d   = last ? stp_err : stp_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         edge_q  <= '0;
         bit_q   <= '0;
         ps_q    <= PRESCALE_WIDTH'(8);
         pen_q   <= 1'b0;
         par_q   <= 1'b0;
         stp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         edge_q  <= edge_d;
         bit_q   <= bit_d;
         ps_q    <= ps_d;
         pen_q   <= pen_d;
         par_q   <= par_d;
         stp_q   <= stp_d;
      end
   end
   assign edge_cnt    = edge_q;
   assign bit_cnt     = bit_q;
   assign strt_chk_en = state_q == START;
   assign deser_en    = state_q == DATA;
   assign par_chk_en  = state_q == PARITY;
   assign stp_chk_en  = state_q == STOP;
   assign dat_samp_en = strt_chk_en | deser_en | par_chk_en | stp_chk_en;
   assign data_valid  = (state_q == DONE) & ~par_q & ~stp_q;
   assign framing_err = (state_q == DONE) & (par_q | stp_q);
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed frames with hand-computed latencies and pulse counts.
module tb_uart_rx_fsm;
   logic       CLK = 1'b0, RST = 1'b1, RX_IN = 1'b1, PAR_EN = 1'b0;
   logic [5:0] prescale = 6'd8;
   logic       glitch_mode = 1'b0, par_mode = 1'b0, stp_mode = 1'b0;
   logic       strt_glitch, par_err, stp_err;
   logic [4:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, framing_err;
   int         total = 0, bad = 0;
   int         lat, dv, fe, des, emax, slast, m;
   logic       found;

   uart_rx_fsm #(.WIDTH(8), .PRESCALE_WIDTH(6)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .prescale(prescale),
      .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
      .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
      .strt_chk_en(strt_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
      .stp_chk_en(stp_chk_en), .data_valid(data_valid), .framing_err(framing_err)
   );

   always #5 CLK = ~CLK;

   // checker models: the glitch, parity and stop flags only assert while their checker is enabled
   assign strt_glitch = glitch_mode & strt_chk_en;
   assign par_err     = par_mode & par_chk_en & (edge_cnt >= 5'd10);
   assign stp_err     = stp_mode & stp_chk_en;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] outs();
      return {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
              data_valid, framing_err};
   endfunction

   // Drives one frame; n counts posedges after RX_IN goes low, lat is the n of the first pulse (0 = none).
   task automatic frame(input int ps, input int ps2, input logic par, input int low, input int limit,
                        output int lat, output int dv, output int fe, output int des,
                        output int emax, output int slast);
      lat = 0; dv = 0; fe = 0; des = 0; emax = 0; slast = 0;
      @(negedge CLK);
      prescale = 6'(ps);
      PAR_EN   = par;
      RX_IN    = 1'b0;
      for (int n = 1; n <= limit; n++) begin
         @(negedge CLK);
         if (n == low) RX_IN = 1'b1;
         if (n == 3) prescale = 6'(ps2);
         if (deser_en) des++;
         if (int'(edge_cnt) > emax) emax = int'(edge_cnt);
         if (strt_chk_en) slast = n;
         if (data_valid) dv++;
         if (framing_err) fe++;
         if ((data_valid || framing_err) && lat == 0) lat = n;
         if (lat != 0 && n >= lat + 3) break;
      end
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      chk("reset_outs", 32'(outs()), 0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      frame(8, 8, 1'b0, 1, 120, lat, dv, fe, des, emax, slast);
      chk("t1_latency", lat, 80);
      chk("t1_dv_count", dv, 1);
      chk("t1_fe_count", fe, 0);
      chk("t1_deser_cycles", des, 64);
      chk("t1_edge_max", emax, 7);

      glitch_mode = 1'b1;
      frame(8, 8, 1'b0, 2, 20, lat, dv, fe, des, emax, slast);
      glitch_mode = 1'b0;
      chk("t2_no_pulse", lat, 0);
      chk("t2_no_deser", des, 0);
      chk("t2_start_last", slast, 7);

      par_mode = 1'b1;
      frame(16, 16, 1'b1, 1, 220, lat, dv, fe, des, emax, slast);
      par_mode = 1'b0;
      chk("t3_latency", lat, 176);
      chk("t3_fe_count", fe, 1);
      chk("t3_dv_count", dv, 0);

      stp_mode = 1'b1;
      frame(32, 32, 1'b0, 1, 360, lat, dv, fe, des, emax, slast);
      stp_mode = 1'b0;
      chk("t4_latency", lat, 320);
      chk("t4_fe_count", fe, 1);
      chk("t4_dv_count", dv, 0);
      chk("t4_edge_max", emax, 31);

      @(negedge CLK);
      prescale = 6'd8;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      @(negedge CLK);
      RX_IN = 1'b1;
      m = 1;
      while (!data_valid && m < 120) begin
         @(negedge CLK);
         m++;
      end
      chk("t5_first_latency", m, 80);
      RX_IN = 1'b0;
      @(negedge CLK);
      RX_IN = 1'b1;
      chk("t5_b2b_start", 32'(strt_chk_en), 1);
      chk("t5_b2b_edge", 32'(edge_cnt), 1);
      m = 1;
      while (!data_valid && m < 120) begin
         @(negedge CLK);
         m++;
      end
      chk("t5_gap", m, 80);
      repeat (3) @(negedge CLK);

      @(negedge CLK);
      prescale = 6'd8;
      RX_IN    = 1'b0;
      found    = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge CLK);
         RX_IN = 1'b1;
         found = deser_en && bit_cnt == 4'd4;
      end
      chk("t6_reach_bit4", 32'(found), 1);
      RST = 1'b1;
      @(negedge CLK);
      chk("t6_reset_outs", 32'(outs()), 0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      chk("t6_idle_outs", 32'(outs()), 0);

      frame(8, 16, 1'b0, 1, 120, lat, dv, fe, des, emax, slast);
      chk("t6_ps_change_latency", lat, 80);
      chk("t6_ps_change_dv", dv, 1);

      frame(12, 12, 1'b0, 1, 120, lat, dv, fe, des, emax, slast);
      chk("ps_other_latency", lat, 80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
